// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: run-time loadable 1..MAX_LEN-bit pattern,
// overlapping or non-overlapping detection, qualified input, saturating match count.
module seq_detect_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x_i,
  output logic               det_o,
  output logic [CNT_W-1:0]   det_cnt_o,
  output logic               cfg_ok_o,
  output logic               cfg_err_o
);

  typedef enum logic [1:0] {UNCFG, FILL, ACTIVE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_nxt;
  logic               ovl_q;
  logic               cfg_legal;
  logic               accept;
  logic               full_nxt;
  logic               hit;

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign accept    = x_valid && (state != UNCFG);

  // Length-aware shift: the newest bit enters at index L-1, so hist[0..L-1]
  // always holds the last L accepted bits oldest-first, aligned with cfg_pat.
  always_comb begin
    hist_nxt = '0;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if (i == int'(len_q) - 1)
        hist_nxt[i] = x_i;
      else if (i < int'(len_q) - 1)
        hist_nxt[i] = hist_q[i+1];
    end
    hist_nxt[MAX_LEN-1] = (len_q == MAX_LEN_L) && x_i;
  end

  assign fill_nxt = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
  assign full_nxt = (fill_nxt >= len_q);
  assign hit      = accept && full_nxt && (((hist_nxt ^ pat_q) & len_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNCFG;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      det_o     <= 1'b0;
      det_cnt_o <= '0;
      cfg_ok_o  <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      det_o     <= 1'b0;
      cfg_err_o <= 1'b0;
      if (cfg_we) begin
        // A write always wins over data in the same cycle; the bit is dropped.
        if (cfg_legal) begin
          pat_q     <= cfg_pat;
          len_q     <= cfg_len;
          ovl_q     <= cfg_overlap;
          hist_q    <= '0;
          fill_q    <= '0;
          det_cnt_o <= '0;
          cfg_ok_o  <= 1'b1;
          state     <= FILL;
        end else begin
          cfg_err_o <= 1'b1;
        end
      end else if (accept) begin
        hist_q <= hist_nxt;
        if (hit) begin
          det_o <= 1'b1;
          if (det_cnt_o != CNT_MAX)
            det_cnt_o <= det_cnt_o + CNT_W'(1);
        end
        if (hit && !ovl_q) begin
          fill_q <= '0;
          state  <= FILL;
        end else begin
          fill_q <= fill_nxt;
          state  <= (fill_nxt == len_q) ? ACTIVE : FILL;
        end
      end
    end
  end

endmodule
